// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory access per request from the control
// unit over a req/ack port, reports completion with done_ls and keeps the
// most recently loaded word on ld_data for the writeback mux.
module load_store_unit #(
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          abort,
  input  logic [1:0]    en_ls,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic          done_ls,
  output logic [15:0]   ld_data,
  output logic          ls_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic        start_op;
  logic        illegal_op;
  logic        timeout_hit;

  // Request decode and timeout detection
  always_comb begin
    start_op    = (en_ls == 2'b01) || (en_ls == 2'b10);
    illegal_op  = (en_ls == 2'b11);
    timeout_hit = (TIMEOUT != 0) && !mem_ack && (cnt == 16'(TIMEOUT - 1));
  end

  // State register; async reset drops the request at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_op) begin
            state_next = REQ;
          end else if (illegal_op) begin
            state_next = DONE;
          end
        end
        REQ: begin
          if (mem_ack || timeout_hit) begin
            state_next = DONE;
          end
        end
        DONE: begin
          // en_ls is still asserted here; going straight to IDLE without
          // looking at it is what prevents a duplicate access.
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // mem_req and done_ls are decoded from the state register so that reset,
  // abort and completion all drop them on exactly the same edge as the state.
  always_comb begin
    mem_req = (state == REQ);
    done_ls = (state == DONE);
  end

  // Datapath registers: access latch, load result, error flag, wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ld_data   <= '0;
      ls_err    <= 1'b0;
      cnt       <= '0;
    end else if (abort) begin
      // Abandoned access: ld_data and ls_err are deliberately kept.
      mem_we <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_op) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_we    <= en_ls[1];
            ls_err    <= 1'b0;
            cnt       <= '0;
          end else if (illegal_op) begin
            ls_err <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              ld_data <= mem_rdata;
            end
            mem_we <= 1'b0;
          end else if (timeout_hit) begin
            if (!mem_we) begin
              ld_data <= '0;
            end
            ls_err <= 1'b1;
            mem_we <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (TIMEOUT overridden to 4).
module tb_load_store_unit;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    en_ls = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [15:0]   wdata = '0;
  logic          done_ls;
  logic [15:0]   ld_data;
  logic          ls_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_rdata = '0;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  load_store_unit #(.AW(AW), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .en_ls     (en_ls),
    .addr      (addr),
    .wdata     (wdata),
    .done_ls   (done_ls),
    .ld_data   (ld_data),
    .ls_err    (ls_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Completed memory handshakes, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_req && mem_ack) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ld", ld_data, 0);
    check("rst_err", ls_err, 0);
    check("rst_done", done_ls, 0);
    reset = 1'b1;
    tick();

    // 1: load, ack in the same cycle
    en_ls = 2'b01; addr = 16'h0040; mem_rdata = 16'hBEEF; mem_ack = 1'b1;
    tick();
    check("t1_req", mem_req, 1);
    check("t1_we", mem_we, 0);
    check("t1_addr", mem_addr, 16'h0040);
    check("t1_done0", done_ls, 0);
    tick();
    check("t1_done", done_ls, 1);
    check("t1_req_off", mem_req, 0);
    check("t1_ld", ld_data, 16'hBEEF);
    mem_ack = 1'b0;
    tick();
    en_ls = 2'b00;
    check("t1_done_off", done_ls, 0);
    check("t1_no_rereq", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_ld_hold", ld_data, 16'hBEEF);
      check("t1_idle_req", mem_req, 0);
    end
    check("t1_acc", acc_cnt, 1);

    // 2: store, ack after 3 wait cycles
    en_ls = 2'b10; addr = 16'h0012; wdata = 16'h1234; mem_ack = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_req", mem_req, 1);
      check("t2_we", mem_we, 1);
      check("t2_addr", mem_addr, 16'h0012);
      check("t2_wdata", mem_wdata, 16'h1234);
      check("t2_done0", done_ls, 0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    check("t2_done", done_ls, 1);
    check("t2_req_off", mem_req, 0);
    check("t2_we_off", mem_we, 0);
    check("t2_ld", ld_data, 16'hBEEF);
    check("t2_err", ls_err, 0);
    mem_ack = 1'b0;
    tick();
    en_ls = 2'b00;
    check("t2_done_off", done_ls, 0);
    check("t2_acc", acc_cnt, 2);

    // 3: timeout with no ack, then a good load clears ls_err
    tick();
    en_ls = 2'b01; addr = 16'h0077; mem_rdata = 16'h5555;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_req", mem_req, 1);
      check("t3_done0", done_ls, 0);
      tick();
    end
    check("t3_req_off", mem_req, 0);
    check("t3_err", ls_err, 1);
    check("t3_ld", ld_data, 0);
    check("t3_done", done_ls, 1);
    tick();
    en_ls = 2'b00;
    check("t3_done_off", done_ls, 0);
    check("t3_err_hold", ls_err, 1);
    tick();
    en_ls = 2'b01; addr = 16'h0005; mem_rdata = 16'hA5A5; mem_ack = 1'b1;
    tick();
    check("t3b_req", mem_req, 1);
    check("t3b_err_clr", ls_err, 0);
    tick();
    check("t3b_done", done_ls, 1);
    check("t3b_ld", ld_data, 16'hA5A5);
    mem_ack = 1'b0;
    tick();
    en_ls = 2'b00;
    check("t3_acc", acc_cnt, 3);

    // 4: illegal op
    tick();
    en_ls = 2'b11;
    tick();
    check("t4_req", mem_req, 0);
    check("t4_err", ls_err, 1);
    check("t4_done", done_ls, 1);
    tick();
    en_ls = 2'b00;
    check("t4_done_off", done_ls, 0);
    check("t4_req_off", mem_req, 0);
    check("t4_ld", ld_data, 16'hA5A5);

    // 5: abort on the 2nd REQ cycle, late ack ignored
    tick();
    en_ls = 2'b01; addr = 16'h0030; mem_rdata = 16'hDEAD;
    tick();
    check("t5_req1", mem_req, 1);
    check("t5_err_clr", ls_err, 0);
    tick();
    check("t5_req2", mem_req, 1);
    abort = 1'b1;
    tick();
    check("t5_req_drop", mem_req, 0);
    check("t5_no_done", done_ls, 0);
    abort = 1'b0; en_ls = 2'b00; mem_ack = 1'b1;
    tick();
    check("t5_late_req", mem_req, 0);
    check("t5_late_done", done_ls, 0);
    check("t5_ld", ld_data, 16'hA5A5);
    mem_ack = 1'b0;
    tick();
    check("t5_done_idle", done_ls, 0);
    check("t5_ld_hold", ld_data, 16'hA5A5);
    check("t5_acc", acc_cnt, 3);

    // 6: load then store with en_ls held through DONE; async reset mid-REQ
    en_ls = 2'b01; addr = 16'h0100; mem_rdata = 16'h0F0F; mem_ack = 1'b1;
    tick();
    check("t6_req", mem_req, 1);
    tick();
    check("t6_done", done_ls, 1);
    check("t6_ld", ld_data, 16'h0F0F);
    mem_ack = 1'b0;
    tick();
    en_ls = 2'b00;
    check("t6_no_rereq", mem_req, 0);
    check("t6_done_off", done_ls, 0);
    tick();
    check("t6_acc", acc_cnt, 4);
    en_ls = 2'b10; addr = 16'h0101; wdata = 16'hCAFE;
    tick();
    check("t6_st_req", mem_req, 1);
    check("t6_st_we", mem_we, 1);
    check("t6_st_wdata", mem_wdata, 16'hCAFE);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_wdata", mem_wdata, 0);
    check("t6_rst_ld", ld_data, 0);
    check("t6_rst_err", ls_err, 0);
    check("t6_rst_done", done_ls, 0);
    en_ls = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    check("t6_post_req", mem_req, 0);
    check("t6_acc_end", acc_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
